// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the display-FIFO read side.
//   rd_state_e  : reader FSM states (IDLE / RD / CAP)
//   DATA_W_DEF  : default FIFO word width
//   POP_CNT_W   : width of the wrapping pop counter
package fifo_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int POP_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_drain_reader_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debounce and rising-edge
// pulse for a raw pushbutton.
//   clk_out1  : clock
//   rst       : synchronous active-high reset
//   btn_raw   : asynchronous button level, active-high
//   btn_pulse : 1-cycle pulse in the cycle the accepted level rises
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk_out1,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync2_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    // The count reaches DEBOUNCE_CYC-1 on the DEBOUNCE_CYC-th mismatching
    // cycle; that edge takes the new level, so a clean press is accepted
    // 2 + DEBOUNCE_CYC cycles after it reaches the synchronizer input.
    always_ff @(posedge clk_out1) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    pulse_q <= sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: read-side controller for the display FIFO. Turns a
// debounced button press (or, with FIFO_AUTO_DRAIN_EN defined, a periodic
// drain timer) into a single pop strobe and captures the popped word.
//   clk_out1, rst  : clock, synchronous active-high reset
//   btn_pop        : raw pop button
//   auto_mode      : auto-drain enable (only with FIFO_AUTO_DRAIN_EN)
//   fifo_empty     : FIFO empty flag
//   fifo_rdata     : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd        : 1-cycle pop strobe
//   out_data       : last popped word (held)
//   out_valid      : 1-cycle pulse when out_data updates
//   pop_count      : successful pops, wraps 255 -> 0
//   underflow_err  : sticky, set by a button request on an empty FIFO
//   busy           : FSM not in IDLE
module fifo_drain_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int DRAIN_PERIOD = 5000000
) (
    input  logic                 clk_out1,
    input  logic                 rst,
    input  logic                 btn_pop,
`ifdef FIFO_AUTO_DRAIN_EN
    input  logic                 auto_mode,
`endif
    input  logic                 fifo_empty,
    input  logic [DATA_W-1:0]    fifo_rdata,
    output logic                 fifo_rd,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    output logic [POP_CNT_W-1:0] pop_count,
    output logic                 underflow_err,
    output logic                 busy
);

    logic btn_req;
    logic auto_req;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk_out1  (clk_out1),
        .rst       (rst),
        .btn_raw   (btn_pop),
        .btn_pulse (btn_req)
    );

`ifdef FIFO_AUTO_DRAIN_EN
    localparam int DRN_W = $clog2(DRAIN_PERIOD);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_PERIOD - 1);

    logic [DRN_W-1:0] drain_q, drain_d;

    always_comb begin
        drain_d = '0;
        if (auto_mode && drain_q != DRN_LAST) drain_d = drain_q + 1'b1;
    end

    always_ff @(posedge clk_out1) begin
        if (rst) drain_q <= '0;
        else     drain_q <= drain_d;
    end

    assign auto_req = auto_mode && (drain_q == DRN_LAST);
`else
    assign auto_req = 1'b0;
`endif

    rd_state_e             state_q;
    logic                  fifo_rd_q;
    logic                  out_valid_q;
    logic [DATA_W-1:0]     data_q;
    logic [POP_CNT_W-1:0]  pop_cnt_q;
    logic                  underflow_q;

    // Requests outside IDLE are simply dropped. Only a button request on an
    // empty FIFO flags underflow; an empty auto request is skipped quietly.
    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state_q     <= IDLE;
            fifo_rd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            pop_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            fifo_rd_q   <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((btn_req || auto_req) && !fifo_empty) begin
                        state_q   <= RD;
                        fifo_rd_q <= 1'b1;
                    end else if (btn_req && fifo_empty) begin
                        underflow_q <= 1'b1;
                    end
                end
                RD: begin
                    state_q     <= CAP;
                    out_valid_q <= 1'b1;
                end
                CAP: begin
                    data_q    <= fifo_rdata;
                    pop_cnt_q <= pop_cnt_q + 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The popped word only appears on fifo_rdata during CAP, so it is passed
    // straight through in that cycle and held from the register afterwards.
    assign out_data      = out_valid_q ? fifo_rdata : data_q;
    assign fifo_rd       = fifo_rd_q;
    assign out_valid     = out_valid_q;
    assign pop_count     = pop_cnt_q;
    assign underflow_err = underflow_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_reader.sv
module tb_fifo_drain_reader;

    localparam int DW  = 4;
    localparam int DEB = 4;
    localparam int DP  = 8;

    logic          clk_out1 = 1'b0;
    logic          rst = 1'b1;
    logic          btn_pop = 1'b0;
`ifdef FIFO_AUTO_DRAIN_EN
    logic          auto_mode = 1'b0;
`endif
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [7:0]    pop_count;
    logic          underflow_err;
    logic          busy;

    fifo_drain_reader #(.DATA_W(DW), .DEBOUNCE_CYC(DEB), .DRAIN_PERIOD(DP)) dut (
        .clk_out1      (clk_out1),
        .rst           (rst),
        .btn_pop       (btn_pop),
`ifdef FIFO_AUTO_DRAIN_EN
        .auto_mode     (auto_mode),
`endif
        .fifo_empty    (fifo_empty),
        .fifo_rdata    (fifo_rdata),
        .fifo_rd       (fifo_rd),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .pop_count     (pop_count),
        .underflow_err (underflow_err),
        .busy          (busy)
    );

    always #5 clk_out1 = ~clk_out1;

    int n_vec = 0, n_err = 0;
    int cyc = 0, rd_cnt = 0, ov_cnt = 0, exp_cnt = 0;
    bit cnt_pend = 0;
    logic [DW-1:0] fq[$];     // FIFO model contents
    logic [DW-1:0] exp_q[$];  // scoreboard: words popped, awaiting out_valid
    int rd_cyc[$];
    logic rd_s;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // FIFO model: pops on the edge where fifo_rd is high, data valid next cycle
    always @(posedge clk_out1) begin
        rd_s = fifo_rd;
        #1;
        if (rd_s && fq.size() > 0) begin
            fifo_rdata = fq.pop_front();
            exp_q.push_back(fifo_rdata);
        end
        fifo_empty = (fq.size() == 0);
    end

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk_out1) begin
        cyc++;
        if (cnt_pend) begin
            chk("pop_count_track", int'(pop_count), exp_cnt);
            cnt_pend = 0;
        end
        if (fifo_rd) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
        end
        if (out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else chk("sb_data", int'(out_data), int'(exp_q.pop_front()));
            exp_cnt  = (exp_cnt + 1) % 256;
            cnt_pend = 1;
        end
    end

    task automatic press(input int hold, input int rel, output int t0);
        @(posedge clk_out1); #1;
        btn_pop = 1'b1;
        t0 = cyc;
        repeat (hold) @(posedge clk_out1);
        #1 btn_pop = 1'b0;
        repeat (rel) @(posedge clk_out1);
        #1;
    endtask

    task automatic glitch_press();
        repeat (5) begin
            @(posedge clk_out1); #1 btn_pop = 1'b1;
            repeat (2) @(posedge clk_out1);
            #1 btn_pop = 1'b0;
            repeat (1) @(posedge clk_out1);
        end
        repeat (12) @(posedge clk_out1);
        #1;
    endtask

    typedef struct {
        bit            glitch;
        bit            load;
        int            nw;
        logic [DW-1:0] w0, w1;
        int            exp_rd;
        bit            exp_uf;
        int            exp_pc;
    } vec_t;

    vec_t vt[4];

    initial begin
        int t0, rd0, ix, ov0;
        bit found;

        vt[0] = '{glitch:0, load:1, nw:2, w0:4'h3, w1:4'h9, exp_rd:1, exp_uf:0, exp_pc:1};
        vt[1] = '{glitch:1, load:0, nw:0, w0:4'h0, w1:4'h0, exp_rd:0, exp_uf:0, exp_pc:1};
        vt[2] = '{glitch:0, load:1, nw:0, w0:4'h0, w1:4'h0, exp_rd:0, exp_uf:1, exp_pc:1};
        vt[3] = '{glitch:0, load:1, nw:1, w0:4'h5, w1:4'h0, exp_rd:1, exp_uf:1, exp_pc:2};

        repeat (3) @(posedge clk_out1);
        #1;
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pop_count", pop_count, 0);
        chk("rst_underflow", underflow_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (vt[i].load) begin
                fq.delete();
                if (vt[i].nw > 0) fq.push_back(vt[i].w0);
                if (vt[i].nw > 1) fq.push_back(vt[i].w1);
                fifo_empty = (fq.size() == 0);
            end
            rd0 = rd_cnt;
            ix  = rd_cyc.size();
            if (vt[i].glitch) glitch_press();
            else press(20, 12, t0);
            repeat (4) @(posedge clk_out1);
            #1;
            chk($sformatf("v%0d_rd_count", i), rd_cnt - rd0, vt[i].exp_rd);
            chk($sformatf("v%0d_underflow", i), underflow_err, vt[i].exp_uf);
            chk($sformatf("v%0d_pop_count", i), pop_count, vt[i].exp_pc);
            if (i == 0) begin
                chk("btn_latency", (rd_cyc.size() > ix) ? rd_cyc[ix] - t0 : -1, 8);
                chk("v0_out_data_held", out_data, 4'h3);
            end
        end

        // Reset while the reader is in RD: word must not be captured
        fq.delete();
        fq.push_back(4'hA);
        fifo_empty = 1'b0;
        ov0 = ov_cnt;
        @(posedge clk_out1); #1 btn_pop = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk_out1);
            if (fifo_rd) found = 1;
        end
        chk("rst_mid_rd_seen", found, 1);
        rst = 1'b1;
        btn_pop = 1'b0;
        @(posedge clk_out1); #1;
        chk("rst_mid_busy", busy, 0);
        @(posedge clk_out1); #1;
        chk("rst_mid_fifo_rd", fifo_rd, 0);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        repeat (5) @(posedge clk_out1);
        #1;
        chk("rst_mid_no_valid", ov_cnt - ov0, 0);
        chk("rst_mid_out_data", out_data, 0);
        chk("rst_mid_pop_count", pop_count, 0);
        chk("rst_mid_busy_after", busy, 0);
        chk("rst_mid_underflow", underflow_err, 0);

        // 257 pops: counter wraps to 0 at 256, then 1
        fq.delete();
        for (int k = 0; k < 257; k++) fq.push_back(DW'($urandom_range(0, 15)));
        fifo_empty = 1'b0;
        for (int p = 1; p <= 257; p++) begin
            press(8, 8, t0);
            if (p == 256) chk("wrap_256", pop_count, 0);
            if (p == 257) chk("wrap_257", pop_count, 1);
        end
        chk("wrap_underflow", underflow_err, 0);

`ifdef FIFO_AUTO_DRAIN_EN
        fq.delete();
        fq.push_back(4'h1);
        fq.push_back(4'h7);
        fq.push_back(4'hE);
        fifo_empty = 1'b0;
        rd0 = rd_cnt;
        ix  = rd_cyc.size();
        auto_mode = 1'b1;
        repeat (60) @(posedge clk_out1);
        #1;
        chk("auto_rd_count", rd_cnt - rd0, 3);
        if (rd_cyc.size() >= ix + 3) begin
            chk("auto_period_1", rd_cyc[ix+1] - rd_cyc[ix], DP);
            chk("auto_period_2", rd_cyc[ix+2] - rd_cyc[ix+1], DP);
        end else begin
            chk("auto_rd_missing", rd_cyc.size() - ix, 3);
        end
        chk("auto_underflow", underflow_err, 0);
        auto_mode = 1'b0;
`endif

        repeat (5) @(posedge clk_out1);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_drain_reader.md
# fifo_drain_reader

Read-side controller for the 4-bit display FIFO. Converts a raw pushbutton, or a periodic auto-drain timer, into single-cycle pop strobes on the FIFO read port and captures each popped nibble. It also tracks pop count and underflow for the display scanner. It sits between the board button/switch pins and the FIFO read port, in the `clk_out1` domain.

## Interface
Parameters:
- `DATA_W`, 4: FIFO word width.
- `DEBOUNCE_CYC`, 50000: consecutive stable cycles required to accept a button level change; minimum 2.
- `DRAIN_PERIOD`, 5000000: cycles between automatic pop requests (with `FIFO_AUTO_DRAIN_EN` only); minimum 4.

Ports:
- `clk_out1`  in  1  Clock.
- `rst`  in  1  Reset: synchronous, active-high; clock `clk_out1`.
- `btn_pop`  in  1  Raw, asynchronous pop pushbutton, active-high.
- `auto_mode`  in  1  Selects auto-drain; present only with `FIFO_AUTO_DRAIN_EN`.
- `fifo_empty`  in  1  FIFO empty flag, registered in FIFO.
- `fifo_rdata`  in  DATA_W  FIFO read data; valid 1 cycle after `fifo_rd`.
- `fifo_rd`  out  1  Pop strobe, 1 cycle wide.
- `out_data`  out  DATA_W  Last popped word, held.
- `out_valid`  out  1  1-cycle pulse when `out_data` updates.
- `pop_count`  out  8  Number of successful pops, wraps 255→0.
- `underflow_err`  out  1  Sticky; set by a pop request while `fifo_empty`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Button path:
  - `btn_pop` passes through a 2-flop synchronizer.
  - A debounce counter increments while the synced level differs from the accepted level, and clears otherwise.
  - At `DEBOUNCE_CYC`, the accepted level takes the synced value and the counter clears.
  - A rising edge of the accepted level produces a 1-cycle `req`.
- FSM states: IDLE, RD, CAP.
  - IDLE, `req`=1, `fifo_empty`=0 → RD.
  - IDLE, `req`=1, `fifo_empty`=1 → stay in IDLE, set `underflow_err`; no `fifo_rd`.
  - RD: `fifo_rd`=1 for exactly this cycle → CAP.
  - CAP: `out_data`←`fifo_rdata`, `out_valid`=1, `pop_count`+1 (mod 256) → IDLE.
- `req` arriving while in RD or CAP is discarded. There is no queuing.
- `underflow_err` clears only on `rst`.
- `fifo_rd` never asserts while `fifo_empty`=1 was sampled in IDLE on that request.

## Timing
- Reset values: `fifo_rd`=0, `out_data`=0, `out_valid`=0, `pop_count`=0, `underflow_err`=0, `busy`=0. Synchronizer, accepted level, debounce and drain counters all 0; FSM in IDLE.
- Button latency: a clean press is accepted 2 + `DEBOUNCE_CYC` cycles after the edge. `req` is high in the cycle the accepted level rises.
- Handshake latency:
  - `fifo_rd` is high in the cycle after `req`.
  - `out_valid` and the new `out_data` are high/valid 2 cycles after `req`.
  - Back-to-back pops are at most one per 3 cycles.
- Bounce shorter than `DEBOUNCE_CYC` produces no `req`. A held button produces exactly one `req`.
- Reset mid-operation: `rst` during RD or CAP forces IDLE at that edge.
  - `fifo_rd` is low from the next cycle.
  - The in-flight word is not captured and `pop_count` is not incremented.
- `pop_count` wrap: 255 + 1 → 0, with no flag.

## Configuration
- `FIFO_AUTO_DRAIN_EN` defined:
  - The `auto_mode` port exists.
  - While `auto_mode`=1, a drain counter counts 0..`DRAIN_PERIOD`-1 and raises `req` at terminal count.
  - An auto request while `fifo_empty`=1 is silently skipped; `underflow_err` is not set.
  - The button path remains active and is OR'd into `req`.
  - `auto_mode`=0 holds the drain counter at 0.
- Not defined: no `auto_mode` port and no drain counter; only the button produces `req`.

## Structure
- Shared package `fifo_pkg`:
  - FSM state enum (IDLE/RD/CAP).
  - `DATA_W` default.
  - Pop-counter width constant (8).
- Sub-module `btn_debounce`: synchronizer, debounce counter and rising-edge pulse. Parameter `DEBOUNCE_CYC`; ports `clk_out1`, `rst`, `btn_raw`, `btn_pulse`.

## Test plan
Benches use `DEBOUNCE_CYC`=4 and `DRAIN_PERIOD`=8.
- FIFO holding 0x3, 0x9 (`fifo_empty`=0); clean press held 20 cycles → one `fifo_rd`. Then `out_valid` with `out_data`=0x3, `pop_count`=1, `underflow_err`=0.
- Press glitching high 2 cycles / low 2 cycles repeatedly → no `req`, no `fifo_rd`.
- `fifo_empty`=1, clean press → no `fifo_rd`, `underflow_err`=1. It stays 1 after a later successful pop of 0x5.
- `rst` asserted in the RD cycle with `fifo_rdata`=0xA → no `out_valid`, `out_data`=0, `pop_count`=0, `busy`=0 after the edge.
- 256 successful pops → `pop_count`=0; the 257th pop → 1.
- `FIFO_AUTO_DRAIN_EN`, `auto_mode`=1, FIFO holding 3 words then empty:
  - `fifo_rd` every 8 cycles, 3 times.
  - Then no `fifo_rd`, and `underflow_err` stays 0.
